// File: rtl/trace_dump.sv
// Retire trace streamer plus post-halt register-file and memory dump on one output port.
// The retire trace FIFO exists only when TRACE_DUMP_TRACE_EN is defined.
module trace_dump #(
    parameter int WORD   = 32,
    parameter int NREG   = 16,
    parameter int NMEM   = 16,
    parameter int TDEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ret_v,
    input  logic [WORD-1:0]         ret_pc,
    input  logic [WORD-1:0]         ret_result,
    input  logic                    ret_wr,
    input  logic [$clog2(NREG)-1:0] ret_reg,
    input  logic                    halt,
    output logic [$clog2(NREG)-1:0] reg_addr,
    input  logic [WORD-1:0]         reg_data,
    output logic [WORD-1:0]         mem_addr,
    input  logic [WORD-1:0]         mem_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD-1:0]         out_data,
    output logic [1:0]              out_tag,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              drop_cnt
);

    // state | meaning
    // IDLE  | tracing retires, waiting for halt
    // DRAIN | flushing queued trace entries
    // REG   | streaming register file, one word per transfer
    // MRD   | memory read address issued, data next cycle
    // MEM   | presenting one memory word
    // DONE  | dump complete, held until reset
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_REG, S_MRD, S_MEM, S_DONE
    } state_t;

    localparam int              RW       = $clog2(NREG);
    localparam logic [RW-1:0]   LAST_REG = RW'(NREG - 1);
    localparam logic [WORD-1:0] LAST_MEM = WORD'(NMEM - 1);

    state_t            state, state_nxt;
    logic [RW-1:0]     ridx;
    logic [WORD-1:0]   midx;
    logic              mem_first;
    logic [WORD-1:0]   mem_hold;
    logic              xfer;
    logic              trace_empty;
    logic              trace_valid;
    logic [WORD-1:0]   trace_data;
    logic [1:0]        trace_tag;

    assign xfer     = out_valid && out_ready;
    assign mem_addr = midx;
    assign busy     = (state == S_DRAIN) || (state == S_REG) || (state == S_MRD) || (state == S_MEM);
    assign done     = (state == S_DONE);

`ifdef TRACE_DUMP_TRACE_EN
    localparam state_t HALT_TGT = S_DRAIN;
    localparam int TW    = $clog2(TDEPTH);
    localparam int RES_W = WORD - 1 - RW;
    localparam int EW    = WORD + RES_W + 1 + RW;
    localparam logic [TW:0] FULL_CNT = TDEPTH[TW:0];

    // entry layout: {pc, result low bits, wr, reg}
    logic [EW-1:0] fifo_mem [TDEPTH];
    logic [TW-1:0] wptr, rptr;
    logic [TW:0]   count;
    logic          half;
    logic          full, push, pop, drop;
    logic [EW-1:0] head;
    logic          unused_res;

    assign unused_res  = ^ret_result[WORD-1:RES_W];
    assign full        = (count == FULL_CNT);
    assign trace_empty = (count == '0);
    assign trace_valid = !trace_empty && ((state == S_IDLE) || (state == S_DRAIN));
    assign pop         = trace_valid && out_ready && half;
    assign push        = ret_v && (state == S_IDLE) && (!full || pop);
    assign drop        = ret_v && (state == S_IDLE) && full && !pop;
    assign head        = fifo_mem[rptr];
    assign trace_tag   = {1'b0, half};
    assign trace_data  = !trace_valid ? '0 :
                         half ? {head[RW], head[RW-1:0], head[RW+1 +: RES_W]} :
                                head[EW-1 -: WORD];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= {ret_pc, ret_result[RES_W-1:0], ret_wr, ret_reg};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            half     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (trace_valid && out_ready) half <= ~half;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    localparam state_t HALT_TGT = S_REG;
    logic unused_ret;

    assign unused_ret  = ^{ret_v, ret_pc, ret_result, ret_wr, ret_reg};
    assign trace_empty = 1'b1;
    assign trace_valid = 1'b0;
    assign trace_data  = '0;
    assign trace_tag   = 2'b00;
    assign drop_cnt    = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (halt) state_nxt = HALT_TGT;
            S_DRAIN: if (trace_empty) state_nxt = S_REG;
            S_REG:   if (xfer && (ridx == LAST_REG)) state_nxt = S_MRD;
            S_MRD:   state_nxt = S_MEM;
            S_MEM:   if (xfer) state_nxt = (midx == LAST_MEM) ? S_DONE : S_MRD;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_tag   = 2'b00;
        reg_addr  = '0;
        case (state)
            S_IDLE, S_DRAIN: begin
                out_valid = trace_valid;
                out_data  = trace_data;
                out_tag   = trace_tag;
            end
            S_REG: begin
                out_valid = 1'b1;
                reg_addr  = ridx;
                out_data  = reg_data;
                out_tag   = 2'b10;
            end
            S_MEM: begin
                out_valid = 1'b1;
                out_data  = mem_first ? mem_data : mem_hold;
                out_tag   = 2'b11;
            end
            default: ;
        endcase
    end

    // mem_data is only guaranteed on the first MEM cycle, so it is held for stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            ridx      <= '0;
            midx      <= '0;
            mem_first <= 1'b0;
            mem_hold  <= '0;
        end else begin
            if ((state == S_REG) && xfer) ridx <= ridx + 1'b1;
            if ((state == S_MEM) && xfer && (midx != LAST_MEM)) midx <= midx + 1'b1;
            mem_first <= (state == S_MRD);
            if (mem_first) mem_hold <= mem_data;
        end
    end

endmodule

// File: tb/tb_trace_dump.sv
// Directed bench for trace_dump: vector table for the dump start, hand sequences for
// reset abort, stalls and (when TRACE_DUMP_TRACE_EN is defined) trace capture/drop.
module tb_trace_dump;
    localparam int NREG = 16;
    localparam int NMEM = 16;

    logic        clk = 1'b0;
    logic        reset, ret_v, ret_wr, halt, out_ready;
    logic [31:0] ret_pc, ret_result, reg_data, mem_addr, mem_data, out_data;
    logic [3:0]  ret_reg, reg_addr;
    logic        out_valid, busy, done;
    logic [1:0]  out_tag;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_tag[$];
    logic [31:0] exp_data[$];
    logic [1:0]  got_tag[$];
    logic [31:0] got_data[$];

    typedef struct {
        bit          halt;
        bit          ready;
        bit          exp_valid;
        logic [1:0]  exp_tag;
        logic [31:0] exp_data;
        bit          exp_busy;
    } vec_t;
    vec_t vecs[$];

    trace_dump #(.WORD(32), .NREG(NREG), .NMEM(NMEM), .TDEPTH(8)) dut (
        .clk(clk), .reset(reset), .ret_v(ret_v), .ret_pc(ret_pc), .ret_result(ret_result),
        .ret_wr(ret_wr), .ret_reg(ret_reg), .halt(halt), .reg_addr(reg_addr),
        .reg_data(reg_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy), .done(done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // register file r[i] = i*0x11; synchronous memory mem[i] = 0xA0+i
    assign reg_data = 32'h11 * {28'd0, reg_addr};
    always @(posedge clk) mem_data <= 32'hA0 + mem_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1; ret_v = 1'b0; halt = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_ret(input logic [31:0] pc, input logic [31:0] res, input logic wr,
                           input logic [3:0] rg);
        ret_v = 1'b1; ret_pc = pc; ret_result = res; ret_wr = wr; ret_reg = rg;
    endtask

    function automatic logic [31:0] pack(input logic wr, input logic [3:0] rg, input logic [31:0] res);
        return (32'(wr) << 31) | (32'(rg) << 27) | (res & 32'h07FF_FFFF);
    endfunction

    task automatic exp_push(input logic [1:0] t, input logic [31:0] d);
        exp_tag.push_back(t);
        exp_data.push_back(d);
    endtask

    task automatic exp_entry(input logic [31:0] pc, input logic [31:0] res, input logic wr,
                             input logic [3:0] rg);
        exp_push(2'b00, pc);
        exp_push(2'b01, pack(wr, rg, res));
    endtask

    task automatic exp_dump(input int from_reg);
        for (int i = from_reg; i < NREG; i++) exp_push(2'b10, 32'(i) * 32'h11);
        for (int i = 0; i < NMEM; i++) exp_push(2'b11, 32'hA0 + 32'(i));
    endtask

    // ready_mode 0: always ready; 1: ready low every third cycle
    task automatic collect(input int ready_mode, input int budget, input bit stop_on_done);
        bit          prev_stall = 1'b0;
        logic [1:0]  pt = '0;
        logic [31:0] pd = '0;
        got_tag.delete();
        got_data.delete();
        for (int c = 0; c < budget; c++) begin
            out_ready = (ready_mode == 0) ? 1'b1 : ((c % 3) != 2);
            #1;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, pd);
                check("stall_tag", out_tag, pt);
            end
            if (out_valid && out_ready) begin
                got_tag.push_back(out_tag);
                got_data.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready;
            pt = out_tag;
            pd = out_data;
            if (stop_on_done && done) break;
            tick();
        end
    endtask

    task automatic compare(input string name);
        check({name, "_count"}, got_tag.size(), exp_tag.size());
        for (int i = 0; i < got_tag.size() && i < exp_tag.size(); i++) begin
            check($sformatf("%s_tag%0d", name, i), got_tag[i], exp_tag[i]);
            check($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
        end
        exp_tag.delete();
        exp_data.delete();
    endtask

    function automatic vec_t mk(bit h, bit r, bit v, logic [1:0] t, logic [31:0] d, bit b);
        vec_t x;
        x.halt = h; x.ready = r; x.exp_valid = v; x.exp_tag = t; x.exp_data = d; x.exp_busy = b;
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        reset = 1'b1; ret_v = 1'b0; ret_pc = '0; ret_result = '0; ret_wr = 1'b0;
        ret_reg = '0; halt = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        tick();

        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_tag", out_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;

        // dump start with a stall and a stray halt in REG
        vecs.push_back(mk(1, 1, 0, 2'b00, 32'h00, 0));
`ifdef TRACE_DUMP_TRACE_EN
        vecs.push_back(mk(0, 1, 0, 2'b00, 32'h00, 1));
`endif
        vecs.push_back(mk(0, 1, 1, 2'b10, 32'h00, 1));
        vecs.push_back(mk(0, 1, 1, 2'b10, 32'h11, 1));
        vecs.push_back(mk(0, 0, 1, 2'b10, 32'h22, 1));
        vecs.push_back(mk(0, 0, 1, 2'b10, 32'h22, 1));
        vecs.push_back(mk(0, 1, 1, 2'b10, 32'h22, 1));
        vecs.push_back(mk(1, 1, 1, 2'b10, 32'h33, 1));
        vecs.push_back(mk(0, 1, 1, 2'b10, 32'h44, 1));
        foreach (vecs[i]) begin
            halt = vecs[i].halt;
            out_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_tag", i), out_tag, vecs[i].exp_tag);
                check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            end
            tick();
        end
        halt = 1'b0;
        exp_dump(5);
        collect(0, 200, 1);
        compare("a_rest");
        check("a_done", done, 1);
        check("a_busy", busy, 0);

        // two retires, the second coinciding with halt, then the full dump
        apply_reset();
        set_ret(32'h40, 32'h1234, 1'b0, 4'd7);
        tick();
        set_ret(32'h44, 32'hFFFF_FFFF, 1'b1, 4'd15);
        halt = 1'b1;
        tick();
        ret_v = 1'b0; halt = 1'b0;
`ifdef TRACE_DUMP_TRACE_EN
        exp_entry(32'h40, 32'h1234, 1'b0, 4'd7);
        exp_entry(32'h44, 32'hFFFF_FFFF, 1'b1, 4'd15);
`endif
        exp_dump(0);
        collect(0, 300, 1);
        compare("b_dump");
        check("b_done", done, 1);
        check("b_busy", busy, 0);
        check("b_drop", drop_cnt, 0);

        // DONE is sticky and ignores retires and halts
        set_ret(32'h80, 32'h1, 1'b1, 4'd1);
        halt = 1'b1;
        tick();
        tick();
        ret_v = 1'b0; halt = 1'b0;
        #1;
        check("done_hold", done, 1);
        check("done_valid", out_valid, 0);
        check("done_drop", drop_cnt, 0);

        // stalls during REG and MEM
        apply_reset();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        exp_dump(0);
        collect(1, 400, 1);
        compare("c_stall");
        check("c_done", done, 1);

        // reset while streaming r5, then restart from r0
        apply_reset();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (out_valid && out_tag == 2'b10 && reg_addr == 4'd5) begin
                found = 1;
                break;
            end
            tick();
        end
        check("d_reached_r5", found, 1);
        reset = 1'b1;
        tick();
        #1;
        check("d_valid", out_valid, 0);
        check("d_done", done, 0);
        check("d_busy", busy, 0);
        check("d_reg_addr", reg_addr, 0);
        reset = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        exp_dump(0);
        collect(0, 300, 1);
        compare("d_restart");
        check("d_done2", done, 1);

`ifdef TRACE_DUMP_TRACE_EN
        // single retire, one-cycle latency, two-word entry
        apply_reset();
        out_ready = 1'b1;
        set_ret(32'h10, 32'h5, 1'b1, 4'd3);
        tick();
        ret_v = 1'b0;
        #1;
        check("t1_valid", out_valid, 1);
        check("t1_tag", out_tag, 2'b00);
        check("t1_data", out_data, 32'h0000_0010);
        tick();
        #1;
        check("t2_tag", out_tag, 2'b01);
        check("t2_data", out_data, 32'h9800_0005);
        tick();
        #1;
        check("t3_valid", out_valid, 0);

        // nine retires into an eight-entry FIFO with no consumer
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            set_ret(32'h100 + 32'(4 * i), 32'(i), 1'(i % 2), 4'(i));
            tick();
        end
        ret_v = 1'b0;
        check("ov_drop", drop_cnt, 1);
        for (int i = 0; i < 8; i++) exp_entry(32'h100 + 32'(4 * i), 32'(i), 1'(i % 2), 4'(i));
        collect(0, 24, 0);
        compare("ov_words");
        #1;
        check("ov_empty", out_valid, 0);

        // full FIFO: retire without pop drops, retire with pop is kept
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_ret(32'h300 + 32'(4 * i), 32'h50 + 32'(i), 1'b1, 4'(i));
            tick();
        end
        set_ret(32'h400, 32'h1, 1'b0, 4'd1);
        out_ready = 1'b1;
        #1;
        check("fp_tag0", out_tag, 2'b00);
        check("fp_data0", out_data, 32'h300);
        tick();
        set_ret(32'h404, 32'h2, 1'b0, 4'd2);
        #1;
        check("fp_tag1", out_tag, 2'b01);
        check("fp_data1", out_data, 32'h8000_0050);
        tick();
        ret_v = 1'b0;
        check("fp_drop", drop_cnt, 2);
        for (int i = 1; i < 8; i++) exp_entry(32'h300 + 32'(4 * i), 32'h50 + 32'(i), 1'b1, 4'(i));
        exp_entry(32'h404, 32'h2, 1'b0, 4'd2);
        collect(0, 24, 0);
        compare("fp_words");

        // drop counter saturates at 255
        apply_reset();
        set_ret(32'h500, 32'h0, 1'b0, 4'd0);
        for (int i = 0; i < 260; i++) tick();
        check("sat_252", drop_cnt, 252);
        for (int i = 0; i < 10; i++) tick();
        ret_v = 1'b0;
        check("sat_255", drop_cnt, 255);
`else
        // retires are ignored without the trace FIFO
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            set_ret(32'h100 + 32'(4 * i), 32'(i), 1'b1, 4'(i));
            tick();
        end
        ret_v = 1'b0;
        #1;
        check("nt_valid", out_valid, 0);
        check("nt_drop", drop_cnt, 0);
        check("nt_busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
